// File: rtl/delay_sched.sv
// Shared delay timer: round-robin arbitration among NREQ requesters, one
// delay at a time, with done/abort pulses and a sticky clamp-error flag.
module delay_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 14,
  parameter int N     = 15000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NREQ-1:0]                        req,
  input  logic [NREQ*CBITS-1:0]                  dly,
  output logic [NREQ-1:0]                        gnt,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   abort,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic                                   err
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, COUNT, DONE} state_e;

  state_e           state_q;
  logic [CBITS-1:0] cnt_q;
  logic [CBITS-1:0] tgt_q;

  logic             win_vld_d;
  logic [OW-1:0]    win_d;
  logic [NREQ-1:0]  win_oh_d;
  logic [CBITS-1:0] win_dly_d;
  logic             over_d;
  logic             own_req_d;
  int               start_d;
  int               dist_d;
  int               best_d;

  // Winner = requester with the smallest round-robin distance from owner+1.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    win_oh_d  = '0;
    win_dly_d = '0;
    dist_d    = 0;
    best_d    = NREQ;
    start_d   = int'(owner) + 1;
    if (start_d >= NREQ) start_d = start_d - NREQ;
    for (int j = 0; j < NREQ; j++) begin
      dist_d = j - start_d;
      if (dist_d < 0) dist_d = dist_d + NREQ;
      if (req[j] && dist_d < best_d) begin
        best_d    = dist_d;
        win_vld_d = 1'b1;
        win_d     = OW'(j);
        win_oh_d  = NREQ'(1) << j;
        win_dly_d = dly[j*CBITS +: CBITS];
      end
    end
    over_d    = int'(win_dly_d) > N;
    own_req_d = req[owner];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      err     <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      owner   <= OW'(NREQ - 1);
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q <= GRANT;
            owner   <= win_d;
            gnt     <= win_oh_d;
            busy    <= 1'b1;
            cnt_q   <= '0;
            tgt_q   <= over_d ? CBITS'(N) : win_dly_d;
            if (over_d) err <= 1'b1;
          end
        end
        GRANT: begin
          if (!own_req_d) begin
            state_q <= IDLE;
            abort   <= 1'b1;
            gnt     <= '0;
            busy    <= 1'b0;
          end else begin
            state_q <= COUNT;
          end
        end
        COUNT: begin
          // Owner withdrawal beats expiry; tgt <= N keeps cnt from wrapping.
          if (!own_req_d) begin
            state_q <= IDLE;
            abort   <= 1'b1;
            gnt     <= '0;
            busy    <= 1'b0;
          end else if (cnt_q == tgt_q) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CBITS'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
